// File: rtl/pkt_hdr_extractor.sv
// Snoops ingress AXI-Stream, builds one PHV from the first HDR_BEATS beats of each packet; parser_valid
// pulses 1 cycle after the completion beat. Never stalls the stream (no ready); remaining beats are drained.
module pkt_hdr_extractor #(
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int HDR_BEATS           = 4,
  parameter int TOT_LENGTH_POS      = 704,
  parameter int PKT_START_POS       = 711,
  parameter int PKT_VEC_WIDTH       = 1735
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  input  logic                             s_axis_tlast,
  output logic                             parser_valid,
  output logic [PKT_VEC_WIDTH-1:0]         pkt_hdr_vec,
  output logic [31:0]                      hdr_pkt_cnt
);

  localparam int DW     = C_S_AXIS_DATA_WIDTH;
  localparam int KEEP_W = DW / 8;
  localparam int HDR_W  = DW * HDR_BEATS;
  localparam int IDX_W  = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DRAIN = 2'd2} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_beat_idx;
  logic [HDR_W-1:0]   r_hdr;
  logic [7:0]         r_bytes;

  logic               w_capture;
  logic               w_complete;
  logic [DW-1:0]      w_masked;
  logic [7:0]         w_keep_cnt;
  logic [HDR_W-1:0]   w_hdr_next;
  logic [7:0]         w_bytes_next;
  logic [6:0]         w_tot_len;
  logic [PKT_VEC_WIDTH-1:0] w_phv;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, CAPTURE: begin
        if (w_complete)     w_state_next = s_axis_tlast ? IDLE : DRAIN;
        else if (w_capture) w_state_next = CAPTURE;
      end
      DRAIN: begin
        if (s_axis_tvalid && s_axis_tlast) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_capture  = s_axis_tvalid && (r_state == IDLE || r_state == CAPTURE);
    w_complete = w_capture && (s_axis_tlast || r_beat_idx == IDX_W'(HDR_BEATS - 1));
  end

  // Beat 0 (taken in IDLE) starts from a clean accumulator rather than whatever was left behind.
  always_comb begin
    w_masked   = '0;
    w_keep_cnt = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (s_axis_tkeep[i]) w_masked[8*i +: 8] = s_axis_tdata[8*i +: 8];
      w_keep_cnt = w_keep_cnt + 8'(s_axis_tkeep[i]);
    end
    w_hdr_next   = (r_state == IDLE) ? '0 : r_hdr;
    w_bytes_next = ((r_state == IDLE) ? 8'd0 : r_bytes) + w_keep_cnt;
    for (int k = 0; k < HDR_BEATS; k++) begin
      if (r_beat_idx == IDX_W'(k)) w_hdr_next[k*DW +: DW] = w_masked;
    end
    w_tot_len = (w_bytes_next > 8'd127) ? 7'd127 : w_bytes_next[6:0];
    w_phv = '0;
    w_phv[PKT_START_POS +: HDR_W] = w_hdr_next;
    w_phv[TOT_LENGTH_POS +: 7]    = w_tot_len;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_idx   <= '0;
      r_hdr        <= '0;
      r_bytes      <= '0;
      parser_valid <= 1'b0;
      pkt_hdr_vec  <= '0;
      hdr_pkt_cnt  <= '0;
    end else begin
      parser_valid <= w_complete;
      if (w_complete) begin
        r_beat_idx  <= '0;
        r_hdr       <= '0;
        r_bytes     <= '0;
        pkt_hdr_vec <= w_phv;
        hdr_pkt_cnt <= hdr_pkt_cnt + 32'd1;
      end else if (w_capture) begin
        r_beat_idx <= r_beat_idx + IDX_W'(1);
        r_hdr      <= w_hdr_next;
        r_bytes    <= w_bytes_next;
      end
    end
  end

endmodule

// File: tb/tb_pkt_hdr_extractor.sv
// Bench for pkt_hdr_extractor: directed packets plus randomized packets with gaps, checked every cycle
// against a packet-level PHV model built straight from the beat arrays.
module tb_pkt_hdr_extractor;

  localparam int HB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [255:0]  s_axis_tdata;
  logic [31:0]   s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          parser_valid;
  logic [1734:0] pkt_hdr_vec;
  logic [31:0]   hdr_pkt_cnt;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic          pend;
  logic [1734:0] pend_vec;
  logic [1734:0] cur_vec;
  logic [31:0]   exp_cnt;

  pkt_hdr_extractor dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .parser_valid (parser_valid),
    .pkt_hdr_vec  (pkt_hdr_vec),
    .hdr_pkt_cnt  (hdr_pkt_cnt)
  );

  always #5 clk = ~clk;

  function automatic int first_diff(input logic [1734:0] a, input logic [1734:0] b);
    for (int i = 0; i < 1735; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  // One clock: inputs already driven; outputs sampled 1 time unit after the edge.
  task automatic tick(input string tag);
    int d;
    @(posedge clk);
    #1;
    n_tests++;
    assert (parser_valid === pend) else begin
      n_fail++;
      $error("FAIL %s pulse: got %0b expected %0b", tag, parser_valid, pend);
    end
    if (pend) cur_vec = pend_vec;
    pend = 1'b0;
    n_tests++;
    assert (pkt_hdr_vec === cur_vec) else begin
      n_fail++;
      d = first_diff(pkt_hdr_vec, cur_vec);
      $error("FAIL %s phv: bit %0d got %0b expected %0b (len got %0d expected %0d)", tag, d,
             pkt_hdr_vec[d], cur_vec[d], pkt_hdr_vec[710:704], cur_vec[710:704]);
    end
    n_tests++;
    assert (hdr_pkt_cnt === exp_cnt) else begin
      n_fail++;
      $error("FAIL %s cnt: got %0d expected %0d", tag, hdr_pkt_cnt, exp_cnt);
    end
  endtask

  // Builds the expected PHV from the whole packet, then streams it; abort_at>=0 stops after that many beats.
  task automatic send_pkt(input string tag, input int n, input logic [31:0] keep_fix, input bit rand_keep,
                          input int gap_pct, input bit aa_data, input int abort_at);
    logic [255:0]  d [8];
    logic [31:0]   kp [8];
    logic [1023:0] h;
    logic [255:0]  junk;
    int bytes, c, nb;
    h = '0;
    bytes = 0;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 8; j++) d[k][32*j +: 32] = aa_data ? 32'hAAAA_AAAA : $urandom;
      kp[k] = rand_keep ? $urandom : keep_fix;
    end
    c = (n < HB) ? n - 1 : HB - 1;
    for (int k = 0; k <= c; k++) begin
      for (int i = 0; i < 32; i++) begin
        if (kp[k][i]) begin
          h[256*k + 8*i +: 8] = d[k][8*i +: 8];
          bytes++;
        end
      end
    end
    nb = (abort_at >= 0) ? abort_at : n;
    for (int k = 0; k < nb; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        for (int j = 0; j < 8; j++) junk[32*j +: 32] = $urandom;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = junk;
        s_axis_tkeep  = $urandom;
        s_axis_tlast  = 1'($urandom);
        tick({tag, "_gap"});
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d[k];
      s_axis_tkeep  = kp[k];
      s_axis_tlast  = (k == n - 1);
      if (k == c) begin
        pend     = 1'b1;
        pend_vec = {h, 7'((bytes > 127) ? 127 : bytes), 704'b0};
        exp_cnt  = exp_cnt + 32'd1;
      end
      tick(tag);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic idle(input int cycles);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    for (int i = 0; i < cycles; i++) tick("idle");
  endtask

  initial begin
    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    pend          = 1'b0;
    pend_vec      = '0;
    cur_vec       = '0;
    exp_cnt       = '0;
    tick("reset");
    tick("reset");
    reset = 1'b0;
    idle(2);

    send_pkt("T1_2beat", 2, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, -1);
    idle(2);
    send_pkt("T2_6beat", 6, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, -1);
    idle(2);
    send_pkt("T3_partial", 1, 32'h0000_FFFF, 1'b0, 0, 1'b1, -1);
    idle(1);
    send_pkt("T4_A", 1, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, -1);
    send_pkt("T4_B", 3, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, -1);
    idle(2);
    send_pkt("T5_gaps", 6, 32'hFFFF_FFFF, 1'b0, 40, 1'b0, -1);
    idle(2);
    send_pkt("last_on_b3", 4, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, -1);
    send_pkt("after_b3", 1, 32'h0000_00FF, 1'b0, 0, 1'b0, -1);
    idle(2);

    send_pkt("T6_abort", 6, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 3);
    reset   = 1'b1;
    exp_cnt = '0;
    cur_vec = '0;
    tick("T6_reset");
    reset = 1'b0;
    idle(1);
    send_pkt("T6_after", 2, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, -1);
    idle(2);

    for (int p = 0; p < 60; p++) begin
      send_pkt("rand", int'($urandom_range(1, 7)), 32'hFFFF_FFFF, 1'($urandom),
               ($urandom_range(1) != 0) ? 30 : 0, 1'b0, -1);
      if ($urandom_range(2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
